// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
//   Shared constants and helpers for the input conditioning front end.
//   - SYNC_STAGES_MIN        : shortest synchronizer chain accepted
//   - CLK_HZ                 : nominal system clock used to derive defaults
//   - DEFAULT_SAMPLE_CNT_MAX : clocks between debounce samples (500 us)
//   - DEFAULT_PULSE_CNT_MAX  : agreeing samples needed to flip a channel
//   - cnt_width(n)           : bits needed to hold the value n
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

   localparam int unsigned SYNC_STAGES_MIN        = 2;
   localparam int unsigned CLK_HZ                 = 125_000_000;
   localparam int unsigned DEFAULT_SAMPLE_CNT_MAX = CLK_HZ / 2_000;
   localparam int unsigned DEFAULT_PULSE_CNT_MAX  = 200;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage : input_conditioner_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Multi-flop synchronizer for asynchronous or foreign-domain static signals.
//   Each bit passes through SYNC_STAGES serial flops; a change on d is visible
//   on q exactly SYNC_STAGES rising edges later. No combinational path d->q.
//
//   Ports
//     clk    in   destination clock
//     rst_n  in   asynchronous active-low reset, clears every stage
//     d      in   WIDTH raw inputs
//     q      out  WIDTH synchronized outputs (last stage)
// -----------------------------------------------------------------------------
module sync_chain
   import input_conditioner_pkg::*;
#(
   parameter int unsigned WIDTH       = 1,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_param_check
      $error("sync_chain: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
   end

   // stage_q[0] is the first (metastability-exposed) flop.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

   always_comb begin
      stage_d = {stage_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule : sync_chain

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Per-channel front end for asynchronous board inputs (buttons, switches):
//   synchronizer -> sample-based symmetric debouncer -> rise/fall detector.
//   All channels share a single debounce sample timer.
//
//   Ports
//     clk               in   system clock
//     rst_n             in   asynchronous active-low reset
//     async_signal      in   WIDTH raw asynchronous inputs
//     sync_signal       out  WIDTH last synchronizer stage
//     debounced_signal  out  WIDTH debounced level
//     rising_edge       out  WIDTH one-cycle pulse on debounced 0->1
//     falling_edge      out  WIDTH one-cycle pulse on debounced 1->0
//     sample_tick       out  shared debounce sample strobe
// -----------------------------------------------------------------------------
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int unsigned WIDTH          = 1,
   parameter int unsigned SYNC_STAGES    = SYNC_STAGES_MIN,
   parameter int unsigned SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
   parameter int unsigned PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX,
   parameter bit          DEBOUNCE       = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_signal,
   output logic [WIDTH-1:0] sync_signal,
   output logic [WIDTH-1:0] debounced_signal,
   output logic [WIDTH-1:0] rising_edge,
   output logic [WIDTH-1:0] falling_edge,
   output logic             sample_tick
);

   if (SAMPLE_CNT_MAX < 2) begin : g_sample_check
      $error("input_conditioner: SAMPLE_CNT_MAX must be at least 2");
   end
   if (PULSE_CNT_MAX < 1) begin : g_pulse_check
      $error("input_conditioner: PULSE_CNT_MAX must be at least 1");
   end

   localparam int unsigned TMR_W = cnt_width(SAMPLE_CNT_MAX - 1);
   localparam int unsigned PC_W  = cnt_width(PULSE_CNT_MAX);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_CNT_MAX - 1);

   // -------------------------------------------------------------------------
   // Synchronizer
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] sync_w;

   sync_chain #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (async_signal),
      .q     (sync_w)
   );

   assign sync_signal = sync_w;

   // -------------------------------------------------------------------------
   // Shared sample timer: counts 0..SAMPLE_CNT_MAX-1; the tick is registered
   // on the wrap so it is high during the cycle after the counter returns to 0.
   // -------------------------------------------------------------------------
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tick_q, tick_d;

   always_comb begin
      tmr_d  = tmr_q + TMR_W'(1);
      tick_d = 1'b0;
      if (tmr_q == TMR_LAST) begin
         tmr_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tmr_q  <= tmr_d;
         tick_q <= tick_d;
      end
   end

   assign sample_tick = tick_q;

   // -------------------------------------------------------------------------
   // Per-channel debouncer and edge detector
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
      logic d_q, d_d;
      logic rise_q, rise_d;
      logic fall_q, fall_d;

      if (DEBOUNCE) begin : g_db
         localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CNT_MAX - 1);

         // c_q counts consecutive disagreeing samples; it clears on the flip,
         // so it never exceeds PULSE_CNT_MAX-1.
         logic [PC_W-1:0] c_q, c_d;

         always_comb begin
            d_d = d_q;
            c_d = c_q;
            if (tick_q) begin
               if (sync_w[i] != d_q) begin
                  if (c_q == PC_LAST) begin
                     d_d = ~d_q;
                     c_d = '0;
                  end else begin
                     c_d = c_q + PC_W'(1);
                  end
               end else begin
                  c_d = '0;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               c_q <= '0;
            end else begin
               c_q <= c_d;
            end
         end
      end else begin : g_bypass
         always_comb begin
            d_d = sync_w[i];
         end
      end

      // Edge flags are computed from the next level so they line up with the
      // first cycle the new debounced level is visible.
      always_comb begin
         rise_d = d_d & ~d_q;
         fall_d = ~d_d & d_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            d_q    <= d_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
         end
      end

      assign debounced_signal[i] = d_q;
      assign rising_edge[i]      = rise_q;
      assign falling_edge[i]     = fall_q;
   end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//   Self-checking bench: two DUTs (debounce on / bypass) share the inputs and
//   are compared every cycle against a behavioural model, plus directed
//   scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

   localparam int W  = 2;
   localparam int NS = 3;
   localparam int S  = 4;
   localparam int P  = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] async_signal = '0;

   logic [W-1:0] sync_a, deb_a, rise_a, fall_a;
   logic         tick_a;
   logic [W-1:0] sync_b, deb_b, rise_b, fall_b;
   logic         tick_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   input_conditioner #(
      .WIDTH          (W),
      .SYNC_STAGES    (NS),
      .SAMPLE_CNT_MAX (S),
      .PULSE_CNT_MAX  (P),
      .DEBOUNCE       (1'b1)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .async_signal     (async_signal),
      .sync_signal      (sync_a),
      .debounced_signal (deb_a),
      .rising_edge      (rise_a),
      .falling_edge     (fall_a),
      .sample_tick      (tick_a)
   );

   input_conditioner #(
      .WIDTH          (W),
      .SYNC_STAGES    (NS),
      .SAMPLE_CNT_MAX (S),
      .PULSE_CNT_MAX  (P),
      .DEBOUNCE       (1'b0)
   ) dut_byp (
      .clk              (clk),
      .rst_n            (rst_n),
      .async_signal     (async_signal),
      .sync_signal      (sync_b),
      .debounced_signal (deb_b),
      .rising_edge      (rise_b),
      .falling_edge     (fall_b),
      .sample_tick      (tick_b)
   );

   // -------------------------------------------------------------------------
   // Behavioural model
   //   sync  = input as it was NS clock edges ago (history queue)
   //   tick  = high when the number of edges since reset is a multiple of S
   //   level = flips once P consecutive sampled values disagreed with it
   // -------------------------------------------------------------------------
   bit [W-1:0] hist[$];
   bit [W-1:0] m_sync, m_deb, m_rise, m_fall, m_bdeb, m_brise, m_bfall;
   bit         m_tick;
   int         since;
   int         run[W];
   bit [W-1:0] nd;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist = {};
         for (int k = 0; k < NS; k++) hist.push_back('0);
         m_sync = '0; m_deb = '0; m_rise = '0; m_fall = '0;
         m_bdeb = '0; m_brise = '0; m_bfall = '0;
         m_tick = 1'b0;
         since  = 0;
         for (int c = 0; c < W; c++) run[c] = 0;
      end else begin
         nd = m_deb;
         if (m_tick) begin
            for (int c = 0; c < W; c++) begin
               if (m_sync[c] != m_deb[c]) begin
                  run[c]++;
                  if (run[c] == P) begin
                     nd[c]  = ~nd[c];
                     run[c] = 0;
                  end
               end else begin
                  run[c] = 0;
               end
            end
         end
         m_rise  = nd & ~m_deb;
         m_fall  = ~nd & m_deb;
         m_deb   = nd;
         m_brise = m_sync & ~m_bdeb;
         m_bfall = ~m_sync & m_bdeb;
         m_bdeb  = m_sync;
         hist.push_back(async_signal);
         void'(hist.pop_front());
         m_sync = hist[0];
         since++;
         m_tick = ((since % S) == 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("cyc_sync",     sync_a, m_sync);
      chk("cyc_tick",     tick_a, m_tick);
      chk("cyc_deb",      deb_a,  m_deb);
      chk("cyc_rise",     rise_a, m_rise);
      chk("cyc_fall",     fall_a, m_fall);
      chk("cyc_byp_sync", sync_b, m_sync);
      chk("cyc_byp_tick", tick_b, m_tick);
      chk("cyc_byp_deb",  deb_b,  m_bdeb);
      chk("cyc_byp_rise", rise_b, m_brise);
      chk("cyc_byp_fall", fall_b, m_bfall);
   end

   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int n, cnt, rises, falls, other, hits;
      bit got, rise_at;
      int hold[W];

      #1 rst_n = 1'b0;
      @(negedge clk); #1;
      chk("rst_sync", sync_a, 0);
      chk("rst_deb",  deb_a,  0);
      chk("rst_edges", {rise_a, fall_a}, 0);
      chk("rst_tick", tick_a, 0);
      @(negedge clk); #1 rst_n = 1'b1;

      // First tick exactly S cycles after release.
      cnt = 0;
      for (int k = 1; k <= S; k++) begin
         @(posedge clk); #1;
         if (tick_a) begin cnt = k; break; end
      end
      chk("first_tick_cycle", cnt, S);

      // Bypass: synchronizer latency and one extra cycle to debounced.
      do_reset();
      repeat (3) @(negedge clk);
      async_signal = 2'b01;
      @(posedge clk); @(posedge clk); #1;
      chk("byp_sync_e2", sync_b[0], 0);
      @(posedge clk); #1;
      chk("byp_sync_e3", sync_b[0], 1);
      chk("byp_deb_e3",  deb_b[0],  0);
      @(posedge clk); #1;
      chk("byp_deb_e4",  deb_b[0],  1);
      chk("byp_rise_e4", rise_b[0], 1);
      @(negedge clk); async_signal = '0;
      repeat (6) @(negedge clk);
      async_signal = 2'b01;
      @(negedge clk); async_signal = '0;
      cnt = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (sync_b[0]) cnt++;
      end
      chk("byp_pulse_len", cnt, 1);

      // Clean press.
      do_reset();
      @(negedge clk); async_signal = 2'b01;
      n = 0; got = 0; rise_at = 0; rises = 0; falls = 0; other = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (rise_a[0]) rises++;
         if (fall_a[0]) falls++;
         if (sync_a[1] | deb_a[1] | rise_a[1] | fall_a[1]) other++;
         if (!got && deb_a[0]) begin got = 1; n = k; rise_at = rise_a[0]; end
      end
      chk("press_seen", got, 1);
      chk_rng("press_latency", n, 12, 16);
      chk("press_rise_first", rise_at, 1);
      chk("press_rises", rises, 1);
      chk("press_falls", falls, 0);
      chk("press_ch1_quiet", other, 0);

      // Release from debounced=1.
      @(negedge clk); async_signal = '0;
      n = 0; got = 0; rises = 0; falls = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (rise_a[0]) rises++;
         if (fall_a[0]) falls++;
         if (!got && !deb_a[0]) begin got = 1; n = k; end
      end
      chk("release_seen", got, 1);
      chk_rng("release_latency", n, 12, 16);
      chk("release_falls", falls, 1);
      chk("release_rises", rises, 0);

      // Glitch rejection: 3 high, 8 low, five times.
      do_reset();
      hits = 0;
      for (int c = 0; c < 55; c++) begin
         @(negedge clk);
         async_signal = {1'b0, ((c % 11) < 3)};
         @(posedge clk); #1;
         if (deb_a[0] | rise_a[0] | fall_a[0]) hits++;
      end
      chk("glitch_hits", hits, 0);

      // Reset in the middle of a count.
      do_reset();
      @(negedge clk); async_signal = 2'b01;
      got = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         if (run[0] == 2) begin got = 1; break; end
      end
      chk("midrst_count_reached", got, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sync", sync_a, 0);
      chk("midrst_deb",  deb_a,  0);
      chk("midrst_edges", {rise_a, fall_a}, 0);
      chk("midrst_tick", tick_a, 0);
      chk("midrst_byp",  {sync_b, deb_b, rise_b, fall_b, tick_b}, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      n = 0; got = 0; rises = 0;
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk); #1;
         if (rise_a[0]) rises++;
         if (!got && deb_a[0]) begin got = 1; n = k; end
      end
      chk("midrst_seen", got, 1);
      chk_rng("midrst_latency", n, 12, 16);
      chk("midrst_rises", rises, 1);

      // Simultaneous channels.
      async_signal = '0;
      do_reset();
      @(negedge clk); async_signal = 2'b11;
      got = 0;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk); #1;
         if (rise_a != '0) begin got = 1; break; end
      end
      chk("sim_rise_seen", got, 1);
      chk("sim_rise_both", rise_a, 2'b11);
      repeat (4) @(negedge clk);
      async_signal = 2'b01;
      got = 0;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk); #1;
         if (fall_a != '0) begin got = 1; break; end
      end
      chk("sim_fall_seen", got, 1);
      chk("sim_fall_ch1", fall_a, 2'b10);
      chk("sim_fall_norise", rise_a, 2'b00);
      chk("sim_fall_deb", deb_a, 2'b01);
      repeat (20) @(negedge clk);
      chk("sim_ch0_holds", deb_a, 2'b01);

      // Randomized traffic with occasional mid-cycle resets.
      for (int c = 0; c < W; c++) hold[c] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < W; c++) begin
            if (hold[c] == 0) begin
               async_signal[c] = 1'($urandom_range(0, 1));
               hold[c] = $urandom_range(1, 24);
            end else begin
               hold[c]--;
            end
         end
         if ($urandom_range(0, 599) == 0) begin
            #1 rst_n = 1'b0;
            @(negedge clk);
            #1 rst_n = 1'b1;
         end
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_input_conditioner

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Per-channel front end for asynchronous board inputs such as buttons and switches. Each channel passes through three stages in order:
- an N-stage flip-flop synchronizer;
- a symmetric, sample-based debouncer;
- a rise/fall edge detector.
Sits between top-level pins and user logic, replacing ad-hoc synchronizer/debouncer/edge-detector chains. All channels share one sample timer.

Parameters:
WIDTH, 1, number of independent channels
SYNC_STAGES, 2, synchronizer flops per channel; must be at least 2 (elaboration error otherwise)
SAMPLE_CNT_MAX, 62500, clock cycles between debounce sample ticks (500 us at 125 MHz); must be at least 2
PULSE_CNT_MAX, 200, consecutive disagreeing samples needed to flip the debounced state; must be at least 1
DEBOUNCE, 1, 1 = debouncer active; 0 = debouncer bypassed (debounced_signal mirrors sync_signal)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
async_signal  in  WIDTH  raw asynchronous inputs
sync_signal  out  WIDTH  last synchronizer stage
debounced_signal  out  WIDTH  debounced level
rising_edge  out  WIDTH  one-cycle pulse on debounced 0->1
falling_edge  out  WIDTH  one-cycle pulse on debounced 1->0
sample_tick  out  1  shared debounce sample strobe, for observability

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset is asynchronous, active-low (rst_n).
  - While rst_n=0, every flop and every output is 0 immediately, without waiting for a clock edge. This includes sync chains, timer, counters, debounced state, edge flags and sample_tick.
- Synchronizer:
  - SYNC_STAGES serial flops per bit.
  - A change on async_signal is visible on sync_signal exactly SYNC_STAGES rising edges later.
  - No combinational path from input to output.
- Sample timer:
  - Counter runs 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - sample_tick is a registered output, high for exactly one cycle when the counter wraps, i.e. once every SAMPLE_CNT_MAX cycles.
  - First tick occurs SAMPLE_CNT_MAX cycles after reset release.
- Debouncer, per channel i, with DEBOUNCE=1:
  - State: level d[i] and counter c[i], width $clog2(PULSE_CNT_MAX+1).
  - On a cycle where sample_tick=1:
    - if sync_signal[i] != d[i] and c[i]==PULSE_CNT_MAX-1: d[i] toggles and c[i] clears;
    - else if sync_signal[i] != d[i]: c[i] increments;
    - else: c[i] clears.
  - Cycles without sample_tick: hold.
  - Any single agreeing sample restarts the count, so glitches shorter than one sample period are rejected.
  - Rise and fall use the same rule.
  - debounced_signal = d.
- Bypass, DEBOUNCE=0:
  - d[i] registers sync_signal[i] every cycle, giving one cycle of extra latency.
  - Counters are not instantiated. sample_tick still runs.
- Edge detector:
  - rising_edge[i] is registered, high for exactly the first cycle in which debounced_signal[i] shows 1 after showing 0. falling_edge mirrors this for 1->0.
  - Never both high on one channel. Never high for two consecutive cycles.
  - Reset release with async_signal high produces no edge until the debouncer flips d, then exactly one rising edge.
- Independence and boundaries:
  - Channels are fully independent apart from the shared tick.
  - Simultaneous flips on several channels produce simultaneous pulses.
  - Reset asserted mid-count discards the count. After release, a full PULSE_CNT_MAX agreeing samples are needed again.
  - Counters saturate by construction, never exceeding PULSE_CNT_MAX-1.
- Latency bounds (DEBOUNCE=1), from an input step held stable until debounced_signal flips:
  - minimum SYNC_STAGES + (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX + 1 cycles;
  - maximum SYNC_STAGES + PULSE_CNT_MAX*SAMPLE_CNT_MAX + 1 cycles.

Decomposition:
- Package input_conditioner_pkg holds:
  - SYNC_STAGES_MIN=2;
  - default timing constants (CLK_HZ=125_000_000, DEFAULT_SAMPLE_CNT_MAX, DEFAULT_PULSE_CNT_MAX);
  - function cnt_width(n) returning $clog2(n+1).
- One sub-module, sync_chain, parametrised by WIDTH and SYNC_STAGES. It contains the flop chain with asynchronous active-low reset and is reused elsewhere for CDC of static signals.
- The timer, debouncer and edge logic stay in the top module as generate-for per channel.

Test Plan:
All directed tests use WIDTH=2, SYNC_STAGES=3, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3 unless stated.
- Sync latency, DEBOUNCE=0, SYNC_STAGES=3: async_signal[0] goes 0->1 and is sampled at edge k -> sync_signal[0]=1 exactly 3 edges later, debounced_signal[0]=1 one edge after that. A 1-cycle async pulse appears as a 1-cycle sync pulse.
- Clean press: async_signal[0] goes 1 and holds for 20 cycles -> debounced_signal[0] rises between cycle 12 and cycle 16 after the step. rising_edge[0] is high for exactly 1 cycle in the first cycle debounced=1. falling_edge stays 0. Channel 1 outputs stay 0.
- Glitch rejection: async_signal[0] high for 3 cycles, then low for 8, repeated 5 times -> debounced_signal[0] stays 0, no edge pulses.
- Release: from debounced=1, async_signal[0] goes 0 and holds -> debounced falls within 16 cycles, with exactly one falling_edge pulse.
- Mid-count reset: with c[0]=2 (two samples seen), pull rst_n low between clock edges -> all outputs 0 before the next edge. After release with input still 1, debounced rises no earlier than 3 ticks (12 cycles) later, with exactly one rising_edge.
- Simultaneous channels: both inputs step to 1 in the same cycle -> rising_edge=2'b11 in one cycle. Then only channel 1 returns to 0 -> only falling_edge[1] pulses, and channel 0 holds.
